// File: rtl/eq_gain_mac_scheduler.sv
// eq_gain_mac_scheduler
//   Time-multiplexed gain/sum engine for an N-band equalizer. One frame of
//   band samples is captured, each band is multiplied by its active gain on a
//   single shared multiplier (one band per cycle), the products are summed,
//   and one saturated output sample is emitted per frame.
//   The gain bank is double-buffered: the host writes shadow registers, and a
//   commit copies shadow -> active only at a frame boundary.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   band_valid     1-cycle pulse: band_data holds a complete frame
//   band_data      band k at [DATA_BIT*(k+1)-1 -: DATA_BIT], signed
//   gain_wr_en     write gain_wr_data into shadow[gain_wr_addr]
//   gain_wr_addr   band index; out-of-range addresses are ignored
//   gain_wr_data   signed gain, Q(GAIN_BIT-FRAC_BIT).FRAC_BIT
//   gain_commit    request shadow -> active copy of all gains
//   data_out       signed equalized sample, held until next out_valid
//   out_valid      1-cycle pulse when data_out updates
//   busy           high whenever the engine is not idle
//   commit_pend    commit requested but not yet applied
//   overrun        sticky: a band_valid was dropped; cleared only by reset
module eq_gain_mac_scheduler #(
  parameter int FILTER_NUM = 8,
  parameter int DATA_BIT   = 16,
  parameter int GAIN_BIT   = 32,
  parameter int FRAC_BIT   = 16,
  parameter int IDX_BIT    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           band_valid,
  input  logic [DATA_BIT*FILTER_NUM-1:0] band_data,
  input  logic                           gain_wr_en,
  input  logic [IDX_BIT-1:0]             gain_wr_addr,
  input  logic [GAIN_BIT-1:0]            gain_wr_data,
  input  logic                           gain_commit,
  output logic [DATA_BIT-1:0]            data_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           commit_pend,
  output logic                           overrun
);

  localparam int PROD_BIT = DATA_BIT + GAIN_BIT;
  localparam int ACC_BIT  = PROD_BIT + IDX_BIT;

  localparam logic [GAIN_BIT-1:0] UNITY = GAIN_BIT'(1) << FRAC_BIT;

  localparam logic signed [ACC_BIT-1:0] SAT_MAX =
    {{(ACC_BIT-DATA_BIT+1){1'b0}}, {(DATA_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] SAT_MIN =
    {{(ACC_BIT-DATA_BIT+1){1'b1}}, {(DATA_BIT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_BIT-1:0]          idx_q, idx_d;
  logic signed [ACC_BIT-1:0]   acc_q, acc_d;
  logic signed [DATA_BIT-1:0]  sample_q [FILTER_NUM];
  logic signed [DATA_BIT-1:0]  sample_d [FILTER_NUM];
  logic signed [GAIN_BIT-1:0]  shadow_q [FILTER_NUM];
  logic signed [GAIN_BIT-1:0]  shadow_d [FILTER_NUM];
  logic signed [GAIN_BIT-1:0]  active_q [FILTER_NUM];
  logic signed [GAIN_BIT-1:0]  active_d [FILTER_NUM];
  logic [DATA_BIT-1:0]         data_out_q, data_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        commit_pend_q, commit_pend_d;
  logic                        overrun_q, overrun_d;

  logic signed [PROD_BIT-1:0]  prod;
  logic signed [ACC_BIT-1:0]   acc_shift;
  logic                        commit_now;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    sample_d      = sample_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    data_out_d    = data_out_q;
    out_valid_d   = 1'b0;
    commit_pend_d = commit_pend_q;
    overrun_d     = overrun_q;
    commit_now    = 1'b0;

    prod      = PROD_BIT'(sample_q[idx_q]) * PROD_BIT'(active_q[idx_q]);
    acc_shift = acc_q >>> FRAC_BIT;

    // Only in-range addresses can match a loop index, so others are dropped.
    for (int unsigned k = 0; k < FILTER_NUM; k++) begin
      if (gain_wr_en && (gain_wr_addr == IDX_BIT'(k))) begin
        shadow_d[k] = gain_wr_data;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Commit is applied at this same edge, so a frame starting now
        // already sees the new gains.
        if (gain_commit) begin
          commit_now = 1'b1;
        end
        if (band_valid) begin
          for (int unsigned k = 0; k < FILTER_NUM; k++) begin
            sample_d[k] = band_data[DATA_BIT*k +: DATA_BIT];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (gain_commit) begin
          commit_pend_d = 1'b1;
        end
        if (band_valid) begin
          overrun_d = 1'b1;
        end
        acc_d = acc_q + ACC_BIT'(prod);
        idx_d = idx_q + IDX_BIT'(1);
        if (idx_q == IDX_BIT'(FILTER_NUM - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (band_valid) begin
          overrun_d = 1'b1;
        end
        // A commit arriving right at the boundary merges with any pending one.
        if (commit_pend_q || gain_commit) begin
          commit_now    = 1'b1;
          commit_pend_d = 1'b0;
        end
        if (acc_shift > SAT_MAX) begin
          data_out_d = {1'b0, {(DATA_BIT-1){1'b1}}};
        end else if (acc_shift < SAT_MIN) begin
          data_out_d = {1'b1, {(DATA_BIT-1){1'b0}}};
        end else begin
          data_out_d = acc_shift[DATA_BIT-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Copy from shadow_d so a write at the commit edge is included.
    if (commit_now) begin
      active_d = shadow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
      commit_pend_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int unsigned k = 0; k < FILTER_NUM; k++) begin
        sample_q[k] <= '0;
        shadow_q[k] <= UNITY;
        active_q[k] <= UNITY;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      sample_q      <= sample_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      data_out_q    <= data_out_d;
      out_valid_q   <= out_valid_d;
      commit_pend_q <= commit_pend_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign commit_pend = commit_pend_q;
  assign overrun     = overrun_q;

endmodule
